// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one FIFO write port among N_REQ valid/ready producers.
// A granted producer may push up to BURST_MAX beats. Each accepted beat is written to the
// FIFO one cycle later from registers. Acceptance is throttled by fifo_full and
// fifo_room_avail, so the FIFO cannot overflow.
//
// Ports:
//   fifo_clk        - clock, rising edge
//   rst             - asynchronous active-low reset
//   req_valid       - per-requester beat valid
//   req_data        - packed beat data, requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   req_last        - per-requester final-beat marker
//   req_ready       - per-requester accept (combinational)
//   fifo_full       - FIFO full flag
//   fifo_room_avail - FIFO free entries
//   fifo_wren       - registered FIFO write enable
//   fifo_wrdata     - registered FIFO write data
//   grant_vld       - a burst grant is active
//   grant_id        - index of the granted requester
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_PTR   = 4,
  parameter int N_REQ      = 4,
  parameter int BURST_MAX  = 4,
  parameter int ID_W       = 2
) (
  input  logic                        fifo_clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  input  logic [FIFO_PTR:0]           fifo_room_avail,
  output logic                        fifo_wren,
  output logic [FIFO_WIDTH-1:0]       fifo_wrdata,
  output logic                        grant_vld,
  output logic [ID_W-1:0]             grant_id
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_cnt_nxt;
  logic                  r_grant_vld, w_gvld_nxt;
  logic [ID_W-1:0]       r_grant_id, w_gid_nxt;
  logic                  r_wren, w_wren_nxt;
  logic [FIFO_WIDTH-1:0] r_wrdata, w_wrdata_nxt;

  logic [FIFO_WIDTH-1:0] w_data_arr [N_REQ];
  logic                  w_pick_vld;
  logic [ID_W-1:0]       w_pick_id;
  logic [ID_W:0]         w_sum;
  logic                  w_space_ok;
  logic                  w_g_valid;
  logic                  w_accept;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_data_arr[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Circular search from r_rr_ptr; iterating from the farthest offset down lets the
  // nearest valid requester win.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    w_sum      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      if (req_valid[w_sum[ID_W-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = w_sum[ID_W-1:0];
      end
    end
  end

  // The write still in flight (r_wren) will consume one free entry.
  assign w_space_ok = !fifo_full && (fifo_room_avail > {{FIFO_PTR{1'b0}}, r_wren});
  assign w_g_valid  = req_valid[r_grant_id];

  always_comb begin
    req_ready    = '0;
    w_accept     = 1'b0;
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr_ptr;
    w_cnt_nxt    = r_beat_cnt;
    w_gvld_nxt   = r_grant_vld;
    w_gid_nxt    = r_grant_id;
    w_wren_nxt   = 1'b0;
    w_wrdata_nxt = r_wrdata;
    unique case (r_state)
      StIdle: begin
        if (w_pick_vld) begin
          w_state_nxt = StBurst;
          w_gid_nxt   = w_pick_id;
          w_gvld_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      StBurst: begin
        req_ready[r_grant_id] = w_space_ok;
        w_accept              = w_g_valid && w_space_ok;
        if (w_accept) begin
          w_wren_nxt   = 1'b1;
          w_wrdata_nxt = w_data_arr[r_grant_id];
          w_cnt_nxt    = r_beat_cnt + 1'b1;
        end
        // Withdrawal, last beat, or full burst all end the grant exactly once.
        if (!w_g_valid ||
            (w_accept && (req_last[r_grant_id] ||
                          r_beat_cnt == CNT_W'(BURST_MAX - 1)))) begin
          w_state_nxt = StIdle;
          w_gvld_nxt  = 1'b0;
          w_rr_nxt    = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      r_wren      <= 1'b0;
      r_wrdata    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      r_grant_vld <= w_gvld_nxt;
      r_grant_id  <= w_gid_nxt;
      r_wren      <= w_wren_nxt;
      r_wrdata    <= w_wrdata_nxt;
    end
  end

  assign fifo_wren   = r_wren;
  assign fifo_wrdata = r_wrdata;
  assign grant_vld   = r_grant_vld;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (default parameters: 32-bit data, 4 requesters,
// bursts of up to 4 beats). Inputs change 1 time unit after the rising edge, and outputs
// are sampled in the same place.
module tb_fifo_wr_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_last;
  logic [3:0]     req_ready;
  logic           fifo_full;
  logic [4:0]     room;
  logic           wren;
  logic [W-1:0]   wrdata;
  logic           grant_vld;
  logic [1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .FIFO_WIDTH(32), .FIFO_PTR(4), .N_REQ(4), .BURST_MAX(4), .ID_W(2)
  ) dut (
    .fifo_clk       (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_room_avail(room),
    .fifo_wren      (wren),
    .fifo_wrdata    (wrdata),
    .grant_vld      (grant_vld),
    .grant_id       (grant_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic do_reset;
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    room      = 5'd16;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    req_valid = 4'hF;
    req_last  = '0;
    req_data  = '1;
    fifo_full = 1'b0;
    room      = 5'd16;
    #2;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %0b exp 0", wren); end
    checks++; if (wrdata !== '0) begin errors++; $display("FAIL reset_wrdata: got %h exp 0", wrdata); end
    checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL reset_gvld: got %0b exp 0", grant_vld); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d exp 0", grant_id); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    tick;
    checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL reset_hold_gvld: got %0b exp 0", grant_vld); end
    do_reset;
  endtask

  // Plan 1: three-beat burst on requester 0, then the search restarts at requester 1.
  task automatic test_single_burst;
    do_reset;
    req_valid = 4'b0001;
    set_data(0, 32'hA0);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_idle_ready: got %b exp 0000", req_ready); end
    tick;
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got vld=%0b id=%0d exp vld=1 id=0", grant_vld, grant_id); end
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL single_wren0: got %0b exp 0", wren); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
    tick;
    checks++; if (wren !== 1'b1 || wrdata !== 32'hA0) begin errors++; $display("FAIL single_beat0: got wren=%0b data=%h exp 1/a0", wren, wrdata); end
    set_data(0, 32'hA1);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready_inflight: got %b exp 0001", req_ready); end
    tick;
    checks++; if (wren !== 1'b1 || wrdata !== 32'hA1) begin errors++; $display("FAIL single_beat1: got wren=%0b data=%h exp 1/a1", wren, wrdata); end
    set_data(0, 32'hA2);
    req_last = 4'b0001;
    tick;
    checks++; if (wren !== 1'b1 || wrdata !== 32'hA2) begin errors++; $display("FAIL single_beat2: got wren=%0b data=%h exp 1/a2", wren, wrdata); end
    checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL single_release: got %0b exp 0", grant_vld); end
    req_valid = 4'b0;
    req_last  = 4'b0;
    tick;
    checks++; if (wren !== 1'b0 || wrdata !== 32'hA2) begin errors++; $display("FAIL single_after: got wren=%0b data=%h exp 0/a2", wren, wrdata); end
    req_valid = 4'b0011;
    tick;
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL single_next_ptr: got vld=%0b id=%0d exp vld=1 id=1", grant_vld, grant_id); end
    req_valid = 4'b0;
  endtask

  // Plan 2: all requesters streaming, no last; grants 0,1,2,3,0 with one idle cycle between.
  task automatic test_round_robin;
    int beats[4];
    logic [3:0] acc;
    int nwr;
    int ph;
    logic exp_vld, exp_wren;
    logic [1:0] exp_id;
    logic [W-1:0] exp_wd;
    do_reset;
    nwr = 0;
    for (int i = 0; i < 4; i++) begin
      beats[i] = 0;
      set_data(i, 32'(32'hB000 + i*16));
    end
    req_valid = 4'hF;
    for (int e = 1; e <= 21; e++) begin
      #1;
      acc = req_valid & req_ready;
      tick;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          beats[i]++;
          set_data(i, 32'(32'hB000 + i*16 + beats[i]));
        end
      end
      ph       = (e - 1) % 5;
      exp_vld  = (ph != 4);
      exp_wren = (ph != 0);
      exp_id   = 2'(((e - 1) / 5) % 4);
      checks++; if (grant_vld !== exp_vld || grant_id !== exp_id) begin errors++; $display("FAIL rr_grant e=%0d: got vld=%0b id=%0d exp vld=%0b id=%0d", e, grant_vld, grant_id, exp_vld, exp_id); end
      checks++; if (wren !== exp_wren) begin errors++; $display("FAIL rr_wren e=%0d: got %0b exp %0b", e, wren, exp_wren); end
      if (exp_wren) begin
        exp_wd = 32'(32'hB000 + ((e - 2) / 5) * 16 + (e - 2) % 5);
        checks++; if (wrdata !== exp_wd) begin errors++; $display("FAIL rr_data e=%0d: got %h exp %h", e, wrdata, exp_wd); end
      end
      if (e >= 2 && wren === 1'b1) nwr++;
    end
    checks++; if (nwr != 16) begin errors++; $display("FAIL rr_write_count: got %0d exp 16", nwr); end
    req_valid = 4'b0;
  endtask

  // Plan 3: room held at 1, so the in-flight write blocks the next accept.
  task automatic test_room_one;
    logic [3:0] acc;
    logic [3:0] exp_rdy;
    logic exp_wren, exp_vld;
    int beat;
    do_reset;
    room      = 5'd1;
    beat      = 0;
    set_data(1, 32'hC100);
    req_valid = 4'b0010;
    for (int e = 1; e <= 9; e++) begin
      #1;
      exp_rdy = (e >= 2 && e <= 8 && e % 2 == 0) ? 4'b0010 : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL room1_ready e=%0d: got %b exp %b", e, req_ready, exp_rdy); end
      acc = req_valid & req_ready;
      tick;
      if (acc[1]) begin
        beat++;
        set_data(1, 32'(32'hC100 + beat));
      end
      exp_wren = (e <= 8 && e % 2 == 0);
      exp_vld  = (e != 8);
      checks++; if (wren !== exp_wren || grant_vld !== exp_vld) begin errors++; $display("FAIL room1_out e=%0d: got wren=%0b vld=%0b exp wren=%0b vld=%0b", e, wren, grant_vld, exp_wren, exp_vld); end
      if (exp_wren) begin
        checks++; if (wrdata !== 32'(32'hC100 + e/2 - 1)) begin errors++; $display("FAIL room1_data e=%0d: got %h exp %h", e, wrdata, 32'(32'hC100 + e/2 - 1)); end
      end
    end
    req_valid = 4'b0;
  endtask

  // Plan 4: fifo_full for two cycles after two beats of requester 2's burst.
  task automatic test_full_stall;
    logic [3:0] acc;
    logic [3:0] exp_rdy [8];
    logic [7:0] exp_wren;
    logic [7:0] exp_vld;
    logic [W-1:0] exp_wd [8];
    int beat;
    exp_rdy  = '{4'b0, 4'b0, 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0100, 4'b0100};
    exp_wren = 8'b1100_1100;
    exp_vld  = 8'b0111_1110;
    exp_wd   = '{32'h0, 32'h0, 32'hC0, 32'hC1, 32'hC1, 32'hC1, 32'hC2, 32'hC3};
    do_reset;
    beat = 0;
    set_data(2, 32'hC0);
    req_valid = 4'b0100;
    for (int e = 1; e <= 7; e++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[e]) begin errors++; $display("FAIL full_ready e=%0d: got %b exp %b", e, req_ready, exp_rdy[e]); end
      acc = req_valid & req_ready;
      tick;
      if (acc[2]) begin
        beat++;
        set_data(2, 32'(32'hC0 + beat));
      end
      checks++; if (wren !== exp_wren[e] || grant_vld !== exp_vld[e] || grant_id !== 2'd2) begin errors++; $display("FAIL full_out e=%0d: got wren=%0b vld=%0b id=%0d exp wren=%0b vld=%0b id=2", e, wren, grant_vld, grant_id, exp_wren[e], exp_vld[e]); end
      if (e >= 2) begin
        checks++; if (wrdata !== exp_wd[e]) begin errors++; $display("FAIL full_data e=%0d: got %h exp %h", e, wrdata, exp_wd[e]); end
      end
      if (e == 3) fifo_full = 1'b1;
      if (e == 5) fifo_full = 1'b0;
    end
    req_valid = 4'b0;
  endtask

  // Plan 5: requester 3 withdraws after one beat; pointer wraps to 0.
  task automatic test_withdraw;
    do_reset;
    req_valid = 4'b1000;
    set_data(3, 32'hD0);
    tick;
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL wd_grant: got vld=%0b id=%0d exp vld=1 id=3", grant_vld, grant_id); end
    tick;
    checks++; if (wren !== 1'b1 || wrdata !== 32'hD0) begin errors++; $display("FAIL wd_beat: got wren=%0b data=%h exp 1/d0", wren, wrdata); end
    req_valid = 4'b0001;
    set_data(0, 32'hD8);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wd_ready: got %b exp 1000", req_ready); end
    tick;
    checks++; if (grant_vld !== 1'b0 || wren !== 1'b0) begin errors++; $display("FAIL wd_release: got vld=%0b wren=%0b exp 0/0", grant_vld, wren); end
    tick;
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL wd_next: got vld=%0b id=%0d exp vld=1 id=0", grant_vld, grant_id); end
    req_valid = 4'b0;
  endtask

  // Plan 6: asynchronous reset in the middle of a burst.
  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0010;
    set_data(1, 32'hE0);
    tick;
    tick;
    checks++; if (wren !== 1'b1 || grant_vld !== 1'b1) begin errors++; $display("FAIL mid_pre: got wren=%0b vld=%0b exp 1/1", wren, grant_vld); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (wren !== 1'b0 || grant_vld !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL mid_async: got wren=%0b vld=%0b rdy=%b exp 0/0/0000", wren, grant_vld, req_ready); end
    checks++; if (wrdata !== '0 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_regs: got data=%h id=%0d exp 0/0", wrdata, grant_id); end
    #1;
    rst = 1'b1;
    req_valid = 4'b0110;
    tick;
    checks++; if (grant_vld !== 1'b1 || grant_id !== 2'd1 || wren !== 1'b0) begin errors++; $display("FAIL mid_regrant: got vld=%0b id=%0d wren=%0b exp 1/1/0", grant_vld, grant_id, wren); end
    req_valid = 4'b0;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    room      = 5'd16;
    test_reset;
    test_single_burst;
    test_round_robin;
    test_room_one;
    test_full_stall;
    test_withdraw;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
